// File: rtl/irq_flag_sched.sv
// Interrupt flag scheduler: reset-dominant flag latches, masked fixed-priority grant,
// and the active-low IRQ / acknowledge / clear handshake into the core.
module irq_flag_sched #(
  parameter int N  = 4,
  parameter int VW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          CLK,
  input  logic          n_RES,
  input  logic [N-1:0]  SET,
  input  logic [N-1:0]  CLR,
  input  logic [N-1:0]  MASK,
  input  logic          ACK,
  output logic          n_IRQ,
  output logic [VW-1:0] VEC,
  output logic          BUSY,
  output logic [N-1:0]  FLAGS
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_CLEAR  = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  logic [1:0]    r_state;
  logic [VW-1:0] r_vec;
  logic [N-1:0]  r_flags;
  logic [N-1:0]  w_pending;
  logic [VW-1:0] w_lowest;

  assign w_pending = r_flags & ~MASK;

  // Descending scan so the lowest pending index is the last one written.
  always_comb begin
    w_lowest = '0;
    for (int i = N - 1; i >= 0; i--)
      if (w_pending[i]) w_lowest = VW'(i);
  end

  // Any clear (software or handshake) beats a same-cycle set; the set is dropped.
  always_ff @(posedge CLK) begin
    if (!n_RES) begin
      r_flags <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (CLR[i] || (r_state == S_CLEAR && r_vec == VW'(i)))
          r_flags[i] <= 1'b0;
        else if (SET[i])
          r_flags[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!n_RES) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pending != '0) begin
            r_vec   <= w_lowest;
            r_state <= S_ASSERT;
          end
        end
        // ACK outranks withdrawal; no preemption by higher-priority arrivals.
        S_ASSERT: begin
          if (ACK)                  r_state <= S_CLEAR;
          else if (!w_pending[r_vec]) r_state <= S_GAP;
        end
        S_CLEAR: r_state <= S_GAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign n_IRQ = (r_state != S_ASSERT);
  assign BUSY  = (r_state != S_IDLE);
  assign VEC   = r_vec;
  assign FLAGS = r_flags;

endmodule

// File: tb/tb_irq_flag_sched.sv
// Directed test of irq_flag_sched: reset, grant latency, priority, clear dominance,
// withdrawal, masking and reset during a handshake.
module tb_irq_flag_sched;

  logic       CLK = 1'b0;
  logic       n_RES;
  logic [3:0] SET, CLR, MASK;
  logic       ACK;
  logic       n_IRQ;
  logic [1:0] VEC;
  logic       BUSY;
  logic [3:0] FLAGS;

  int n_checks = 0;
  int n_fail   = 0;

  irq_flag_sched #(.N(4)) dut (
    .CLK(CLK), .n_RES(n_RES), .SET(SET), .CLR(CLR), .MASK(MASK), .ACK(ACK),
    .n_IRQ(n_IRQ), .VEC(VEC), .BUSY(BUSY), .FLAGS(FLAGS)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_RES = 1'b0; SET = 4'b1111; CLR = 4'b0; MASK = 4'b0; ACK = 1'b0;

    // Reset holds everything off even with all sets active
    tick(); tick();
    chk("rst_flags", FLAGS, 4'b0000);
    chk("rst_nirq",  n_IRQ, 1'b1);
    chk("rst_busy",  BUSY,  1'b0);
    chk("rst_vec",   VEC,   2'd0);
    n_RES = 1'b1;
    tick();
    chk("rel_flags", FLAGS, 4'b1111);
    chk("rel_nirq",  n_IRQ, 1'b1);
    SET = 4'b0; n_RES = 1'b0;
    tick();
    n_RES = 1'b1;

    // Single source: grant two edges after SET sampled
    SET = 4'b0100;
    tick();
    chk("s_flags", FLAGS, 4'b0100);
    chk("s_nirq0", n_IRQ, 1'b1);
    SET = 4'b0;
    tick();
    chk("s_nirq1", n_IRQ, 1'b0);
    chk("s_vec",   VEC,   2'd2);
    chk("s_busy1", BUSY,  1'b1);
    ACK = 1'b1;
    tick();
    chk("s_ack_nirq",  n_IRQ, 1'b1);
    chk("s_ack_flags", FLAGS, 4'b0100);
    chk("s_ack_busy",  BUSY,  1'b1);
    ACK = 1'b0;
    tick();
    chk("s_clr_flags", FLAGS, 4'b0000);
    chk("s_gap_busy",  BUSY,  1'b1);
    tick();
    chk("s_idle_busy", BUSY,  1'b0);

    // Priority without preemption
    SET = 4'b1010;
    tick();
    chk("p_flags", FLAGS, 4'b1010);
    SET = 4'b0;
    tick();
    chk("p_vec1",  VEC,   2'd1);
    chk("p_nirq1", n_IRQ, 1'b0);
    SET = 4'b0001;
    tick();
    chk("p_flags2",  FLAGS, 4'b1011);
    chk("p_nopre",   VEC,   2'd1);
    chk("p_nopre_n", n_IRQ, 1'b0);
    SET = 4'b0; ACK = 1'b1;
    tick();
    chk("p_gapA0", n_IRQ, 1'b1);
    ACK = 1'b0;
    tick();
    chk("p_gapA1", n_IRQ, 1'b1);
    chk("p_flags3", FLAGS, 4'b1001);
    tick();
    chk("p_gapA2", n_IRQ, 1'b1);
    tick();
    chk("p_vec0",  VEC,   2'd0);
    chk("p_nirq0", n_IRQ, 1'b0);
    ACK = 1'b1;
    tick();
    chk("p_gapB0", n_IRQ, 1'b1);
    ACK = 1'b0;
    tick();
    chk("p_gapB1", n_IRQ, 1'b1);
    tick();
    chk("p_gapB2", n_IRQ, 1'b1);
    tick();
    chk("p_vec3",   VEC,   2'd3);
    chk("p_nirq3",  n_IRQ, 1'b0);
    chk("p_flags4", FLAGS, 4'b1000);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    tick();
    chk("p_flags5", FLAGS, 4'b0000);
    tick();
    chk("p_idle", BUSY, 1'b0);

    // Clear dominates a same-cycle set
    SET = 4'b1000; CLR = 4'b1000;
    tick();
    chk("cd_flags", FLAGS, 4'b0000);
    chk("cd_nirq",  n_IRQ, 1'b1);
    SET = 4'b0; CLR = 4'b0;
    tick();
    chk("cd_nirq2", n_IRQ, 1'b1);
    chk("cd_busy",  BUSY,  1'b0);

    // Handshake clear beats a set arriving in the CLEAR cycle
    SET = 4'b0010;
    tick();
    SET = 4'b0;
    tick();
    chk("hc_vec", VEC, 2'd1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0; SET = 4'b0010;
    tick();
    chk("hc_flags", FLAGS, 4'b0000);
    SET = 4'b0;
    tick();
    chk("hc_busy", BUSY, 1'b0);
    tick();
    chk("hc_noreq", n_IRQ, 1'b1);

    // Withdrawal by software clear
    SET = 4'b0100;
    tick();
    SET = 4'b0;
    tick();
    chk("w_vec",  VEC,   2'd2);
    chk("w_nirq", n_IRQ, 1'b0);
    CLR = 4'b0100;
    tick();
    chk("w_flags", FLAGS, 4'b0000);
    chk("w_still", n_IRQ, 1'b0);
    CLR = 4'b0;
    tick();
    chk("w_drop", n_IRQ, 1'b1);
    chk("w_gap",  BUSY,  1'b1);
    tick();
    chk("w_idle", BUSY, 1'b0);

    // Mask blocks arbitration but not latching
    MASK = 4'b0001; SET = 4'b0001;
    tick();
    chk("m_flags", FLAGS, 4'b0001);
    SET = 4'b0;
    tick(); tick();
    chk("m_nirq",   n_IRQ, 1'b1);
    chk("m_busy",   BUSY,  1'b0);
    chk("m_flags2", FLAGS, 4'b0001);
    MASK = 4'b0;
    tick();
    chk("m_grant", n_IRQ, 1'b0);
    chk("m_vec",   VEC,   2'd0);
    MASK = 4'b0001;
    tick();
    chk("m_wd_nirq", n_IRQ, 1'b1);
    chk("m_wd_busy", BUSY,  1'b1);
    chk("m_wd_flag", FLAGS, 4'b0001);
    MASK = 4'b0;
    tick();
    chk("m_wd_idle", BUSY, 1'b0);
    tick();
    chk("m_regrant", n_IRQ, 1'b0);

    // Reset in the same cycle as ACK discards the handshake
    n_RES = 1'b0; ACK = 1'b1;
    tick();
    chk("ra_nirq",  n_IRQ, 1'b1);
    chk("ra_flags", FLAGS, 4'b0000);
    chk("ra_busy",  BUSY,  1'b0);
    chk("ra_vec",   VEC,   2'd0);
    n_RES = 1'b1; ACK = 1'b0;
    tick();
    chk("ra_noclr", BUSY,  1'b0);
    chk("ra_nirq2", n_IRQ, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
